// File: rtl/pot_filter_pkg.sv
// Shared definitions for the potentiometer filter block.
//   - Default parameter values for sample width, IIR shift and hysteresis.
//   - Channel count and channel index width.
//   - Scan FSM state encoding.
package pot_filter_pkg;

  localparam int unsigned ADC_WIDTH_DEF = 8;
  localparam int unsigned SHIFT_DEF     = 2;
  localparam int unsigned HYST_DEF      = 2;

  localparam int unsigned NUM_CHAN = 8;
  localparam int unsigned CHAN_W   = 3;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCapture,
    StFilter,
    StCompare,
    StEmit
  } state_e;

endpackage

// File: rtl/pot_chan_ram.sv
// Per-channel store of the last reported value.
// An 8-entry distributed RAM with one synchronous write port and two
// asynchronous read ports: one used internally by the compare stage, one
// exposed as the readback port.
//   clk      : clock
//   reset    : synchronous active-high reset, clears every entry
//   wr_en    : write strobe (event handshake)
//   wr_addr  : channel being written
//   wr_data  : value being written
//   cmp_addr : internal read address (current scan channel)
//   cmp_q    : internal read data, combinational
//   rd_addr  : readback address
//   rd_q     : readback data, combinational
module pot_chan_ram
  import pot_filter_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [CHAN_W-1:0]    wr_addr,
  input  logic [ADC_WIDTH-1:0] wr_data,
  input  logic [CHAN_W-1:0]    cmp_addr,
  output logic [ADC_WIDTH-1:0] cmp_q,
  input  logic [CHAN_W-1:0]    rd_addr,
  output logic [ADC_WIDTH-1:0] rd_q
);

  logic [ADC_WIDTH-1:0] mem_q [NUM_CHAN];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign cmp_q = mem_q[cmp_addr];
  assign rd_q  = mem_q[rd_addr];

endmodule

// File: rtl/pot_filter.sv
// Eight-channel potentiometer smoother with change reporting.
// Scans the ADC sample file round-robin, runs a first-order IIR per channel
// (weight 1/2^SHIFT), and emits a valid/ready event whenever the filtered
// value has moved far enough from the last reported value.
//   clk       : clock
//   reset     : synchronous active-high reset
//   scan_en   : enables round-robin scanning
//   adc_addr  : read address into the ADC sample file (always the scan channel)
//   adc_q     : raw sample for adc_addr, combinational from the file
//   evt_valid : an event is presented
//   evt_ready : consumer accepts the event
//   evt_chan  : channel of the presented event
//   evt_value : new reported value of the presented event
//   rd_addr   : readback address for reported values
//   rd_q      : reported value of channel rd_addr, combinational
module pot_filter
  import pot_filter_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int unsigned SHIFT     = SHIFT_DEF,
  parameter int unsigned HYST      = HYST_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_en,
  output logic [CHAN_W-1:0]    adc_addr,
  input  logic [ADC_WIDTH-1:0] adc_q,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CHAN_W-1:0]    evt_chan,
  output logic [ADC_WIDTH-1:0] evt_value,
  input  logic [CHAN_W-1:0]    rd_addr,
  output logic [ADC_WIDTH-1:0] rd_q
);

  // Accumulator holds the filtered value scaled by 2^SHIFT. Its steady state
  // for input s is s<<SHIFT, and acc - (acc>>SHIFT) + s never exceeds that
  // width, so the extra SHIFT bits are sufficient.
  localparam int unsigned AccW = ADC_WIDTH + SHIFT;
  localparam logic [ADC_WIDTH-1:0] HystV = ADC_WIDTH'(HYST);

  state_e                state_q;
  logic [CHAN_W-1:0]     ch_q;
  logic [ADC_WIDTH-1:0]  sample_q;
  logic [AccW-1:0]       acc_q [NUM_CHAN];
  logic [NUM_CHAN-1:0]   primed_q;
  // Set once a channel has completed its first event handshake; until then
  // every compare raises an event so the consumer learns the initial value.
  logic [NUM_CHAN-1:0]   seen_q;

  logic [AccW-1:0]       acc_cur;
  logic [AccW-1:0]       acc_step;
  logic [AccW-1:0]       acc_load;
  logic [ADC_WIDTH-1:0]  filt;
  logic [ADC_WIDTH-1:0]  rep_cur;
  logic [ADC_WIDTH-1:0]  delta;
  logic                  at_endpoint;
  logic                  raise_evt;
  logic                  handshake;
  state_e                leave_state;

  assign adc_addr  = ch_q;
  assign handshake = evt_valid && evt_ready;

  // Filter datapath, evaluated against the current channel's accumulator.
  assign acc_cur  = acc_q[ch_q];
  assign acc_step = acc_cur - (acc_cur >> SHIFT) + AccW'(sample_q);
  assign acc_load = AccW'(sample_q) << SHIFT;
  assign filt     = ADC_WIDTH'(acc_cur >> SHIFT);

  // Change detection against the last reported value of this channel.
  always_comb begin
    delta = '0;
    if (filt >= rep_cur) begin
      delta = filt - rep_cur;
    end else begin
      delta = rep_cur - filt;
    end
  end

  // Small moves onto 0 or full scale still report, otherwise hysteresis could
  // leave the reported value stuck just short of an endpoint.
  assign at_endpoint = (filt != rep_cur) && ((filt == '0) || (filt == '1));
  assign raise_evt   = !seen_q[ch_q] || (delta >= HystV) || at_endpoint;

  assign leave_state = scan_en ? StAddr : StIdle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      sample_q  <= '0;
      primed_q  <= '0;
      seen_q    <= '0;
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_value <= '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_en) begin
            state_q <= StAddr;
          end
        end
        StAddr: begin
          state_q <= StCapture;
        end
        StCapture: begin
          sample_q <= adc_q;
          state_q  <= StFilter;
        end
        StFilter: begin
          if (!primed_q[ch_q]) begin
            // First visit: start at the sample instead of ramping up from 0.
            acc_q[ch_q]    <= acc_load;
            primed_q[ch_q] <= 1'b1;
          end else begin
            acc_q[ch_q] <= acc_step;
          end
          state_q <= StCompare;
        end
        StCompare: begin
          if (raise_evt) begin
            evt_valid <= 1'b1;
            evt_chan  <= ch_q;
            evt_value <= filt;
            state_q   <= StEmit;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= leave_state;
          end
        end
        StEmit: begin
          // Hold everything until accepted; the scan stalls here.
          if (evt_ready) begin
            evt_valid    <= 1'b0;
            seen_q[ch_q] <= 1'b1;
            ch_q         <= ch_q + 1'b1;
            state_q      <= leave_state;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  pot_chan_ram #(
    .ADC_WIDTH (ADC_WIDTH)
  ) u_reported (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (handshake),
    .wr_addr  (evt_chan),
    .wr_data  (evt_value),
    .cmp_addr (ch_q),
    .cmp_q    (rep_cur),
    .rd_addr  (rd_addr),
    .rd_q     (rd_q)
  );

endmodule

// File: tb/tb_pot_filter.sv
module tb_pot_filter;
  import pot_filter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic [2:0] adc_addr;
  logic [7:0] adc_q;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_chan;
  logic [7:0] evt_value;
  logic [2:0] rd_addr;
  logic [7:0] rd_q;

  logic [7:0] adc_mem [8];
  assign adc_q = adc_mem[adc_addr];

  always #5 clk = ~clk;

  pot_filter #(
    .ADC_WIDTH (8),
    .SHIFT     (2),
    .HYST      (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .adc_addr  (adc_addr),
    .adc_q     (adc_q),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_value (evt_value),
    .rd_addr   (rd_addr),
    .rd_q      (rd_q)
  );

  typedef struct packed {
    logic [2:0] chan;
    logic [7:0] value;
  } evt_t;

  evt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted event is popped against the scoreboard.
  always @(negedge clk) begin
    evt_t e;
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got ch%0d value %0d expected no event",
                 evt_chan, evt_value);
      end else begin
        e = exp_q.pop_front();
        check("evt_chan", 32'(evt_chan), 32'(e.chan));
        check("evt_value", 32'(evt_value), 32'(e.value));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic push(input int ch, input int v);
    evt_t e;
    e.chan  = 3'(ch);
    e.value = 8'(v);
    exp_q.push_back(e);
  endtask

  task automatic push_firsts();
    for (int i = 0; i < 8; i++) push(i, adc_mem[i]);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) adc_mem[i] = 8'(10 * (i + 1));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_drain_left"}, 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    step(1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!evt_valid && n < budget) begin
      step(1);
      n++;
    end
    check({name, "_evt_valid_seen"}, 32'(evt_valid), 1);
  endtask

  task automatic check_rd(input string name, input int ch, input int v);
    rd_addr = 3'(ch);
    #1;
    check(name, 32'(rd_q), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] a0;
    logic [2:0] h_chan;
    logic [7:0] h_value;
    bit         stable;
    bit         addr_frozen;
    int         n;
    int         s2_vals[13] = '{125, 143, 158, 168, 176, 182, 187, 190, 192, 194, 196, 198, 200};

    reset     = 1'b1;
    scan_en   = 1'b0;
    evt_ready = 1'b1;
    rd_addr   = '0;
    set_ramp();

    // Scenario 1: reset state, first reports in order, then silence.
    do_reset();
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_evt_chan", 32'(evt_chan), 0);
    check("rst_evt_value", 32'(evt_value), 0);
    check("rst_adc_addr", 32'(adc_addr), 0);
    for (int i = 0; i < 8; i++) check_rd("rst_rd_q", i, 0);
    push_firsts();
    scan_en = 1'b1;
    wait_drain("s1", 200);
    step(70);
    for (int i = 0; i < 8; i++) check_rd("s1_rd_q", i, 10 * (i + 1));
    // Quiet sweep: channel advances every 4 cycles.
    a0 = adc_addr;
    n  = 0;
    while (adc_addr == a0 && n < 20) begin step(1); n++; end
    a0 = adc_addr;
    n  = 0;
    while (adc_addr == a0 && n < 20) begin step(1); n++; end
    check("quiet_chan_cycles", 32'(n), 4);

    // Scenario 2: ch3 primed at 100, step to 200.
    scan_en = 1'b0;
    set_ramp();
    adc_mem[3] = 8'd100;
    do_reset();
    push_firsts();
    scan_en = 1'b1;
    wait_drain("s2_first", 200);
    step(40);
    adc_mem[3] = 8'd200;
    foreach (s2_vals[i]) push(3, s2_vals[i]);
    wait_drain("s2_step", 2000);
    step(100);
    check_rd("s2_rd_q3", 3, 200);

    // Scenario 3a: reported 254, input 255 -> endpoint event 255.
    scan_en = 1'b0;
    set_ramp();
    adc_mem[5] = 8'd254;
    do_reset();
    push_firsts();
    scan_en = 1'b1;
    wait_drain("s3a_first", 200);
    step(40);
    adc_mem[5] = 8'd255;
    push(5, 255);
    wait_drain("s3a_255", 500);
    step(40);
    check_rd("s3a_rd_q5", 5, 255);

    // Scenario 3b: reported 1, input 0 -> endpoint event 0.
    scan_en = 1'b0;
    adc_mem[5] = 8'd1;
    do_reset();
    push_firsts();
    scan_en = 1'b1;
    wait_drain("s3b_first", 200);
    step(40);
    adc_mem[5] = 8'd0;
    push(5, 0);
    wait_drain("s3b_0", 500);
    step(40);
    check_rd("s3b_rd_q5", 5, 0);

    // Scenario 4: 50 cycles of backpressure during EMIT.
    scan_en   = 1'b0;
    evt_ready = 1'b0;
    set_ramp();
    do_reset();
    push_firsts();
    scan_en = 1'b1;
    wait_valid("s4", 20);
    h_chan      = evt_chan;
    h_value     = evt_value;
    a0          = adc_addr;
    stable      = 1'b1;
    addr_frozen = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (!evt_valid || evt_chan != h_chan || evt_value != h_value) stable = 1'b0;
      if (adc_addr != a0) addr_frozen = 1'b0;
    end
    check("s4_evt_stable", 32'(stable), 1);
    check("s4_adc_addr_frozen", 32'(addr_frozen), 1);
    check("s4_held_chan", 32'(h_chan), 0);
    check("s4_held_value", 32'(h_value), 10);
    evt_ready = 1'b1;
    wait_drain("s4", 200);
    step(70);

    // Scenario 5: reset during EMIT drops the pending event.
    scan_en   = 1'b0;
    evt_ready = 1'b0;
    do_reset();
    scan_en = 1'b1;
    wait_valid("s5", 20);
    reset = 1'b1;
    step(1);
    check("s5_valid_after_reset", 32'(evt_valid), 0);
    check_rd("s5_rd_q0", 0, 0);
    evt_ready = 1'b1;
    push_firsts();
    reset = 1'b0;
    wait_drain("s5", 200);
    step(70);

    // Scenario 6: scan_en drops while ch0 is in CAPTURE.
    scan_en = 1'b0;
    do_reset();
    scan_en = 1'b1;
    step(2);
    scan_en = 1'b0;
    check("s6_addr_mid", 32'(adc_addr), 0);
    push(0, 10);
    wait_drain("s6_ch0", 20);
    step(20);
    check("s6_idle_addr", 32'(adc_addr), 1);
    check("s6_idle_valid", 32'(evt_valid), 0);
    for (int i = 1; i < 8; i++) push(i, adc_mem[i]);
    scan_en = 1'b1;
    wait_drain("s6_resume", 200);
    step(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
